sprite_anim_drawer: RTL and testbench



---
 rtl/sprite_pkg.sv | 30 +++
 rtl/anim_sequencer.sv | 63 ++++++
 rtl/sprite_anim_drawer.sv | 107 ++++++++++
 tb/tb_sprite_anim_drawer.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/sprite_pkg.sv
// Shared sprite-renderer definitions: play modes, sprite ROM layout and the
// default see-through palette index.
package sprite_pkg;

    typedef enum logic [1:0] {
        MODE_LOOP    = 2'b00,
        MODE_HOLD    = 2'b01,
        MODE_ONESHOT = 2'b10,
        MODE_HIDE    = 2'b11
    } anim_mode_t;

    // Sprite ROM layout: base address of frame 0 pixel (0,0) and size.
    localparam int RUNNER_BASE   = 207867;
    localparam int RUNNER_SIZE_X = 88;
    localparam int RUNNER_SIZE_Y = 94;
    localparam int CACTUS_BASE   = 190000;
    localparam int CACTUS_SIZE_X = 48;
    localparam int CACTUS_SIZE_Y = 96;
    localparam int BIRD_BASE     = 240000;
    localparam int BIRD_SIZE_X   = 92;
    localparam int BIRD_SIZE_Y   = 80;

    localparam int DEFAULT_TRANSPARENT = 0;

    // Address distance between consecutive animation frames of a sprite.
    function automatic int frame_stride(input int size_x, input int size_y);
        return size_x * size_y;
    endfunction

endpackage

// File: rtl/anim_sequencer.sv
// Animation frame sequencer: steps through NUM_FRAMES frames, each shown
// for FRAME_HOLD video frames, under the selected play mode.
module anim_sequencer
    import sprite_pkg::*;
#(
    parameter int NUM_FRAMES = 2,
    parameter int FRAME_HOLD = 10
) (
    input  logic                          pixel_Clk,
    input  logic                          Reset,
    input  logic                          frame_tick,
    input  logic                          restart,
    input  anim_mode_t                    mode,
    output logic [$clog2(NUM_FRAMES):0]   anim_idx,
    output logic                          anim_done
);

    localparam int IDX_W  = $clog2(NUM_FRAMES) + 1;
    localparam int HOLD_W = (FRAME_HOLD < 2) ? 1 : $clog2(FRAME_HOLD + 1);

    localparam logic [HOLD_W-1:0] HOLD_ONE = HOLD_W'(1);
    localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(FRAME_HOLD);
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(NUM_FRAMES - 1);

    logic [HOLD_W-1:0] hold_cnt;
    logic              done_q;

    // Advance the animation only on frame_tick; restart rewinds and wins over a tick.
    always_ff @(posedge pixel_Clk) begin
        if (Reset || restart) begin
            anim_idx <= '0;
            hold_cnt <= HOLD_ONE;
            done_q   <= 1'b0;
        end else begin
            if (frame_tick && (mode == MODE_LOOP || mode == MODE_ONESHOT)) begin
                if (hold_cnt == HOLD_MAX) begin
                    if (anim_idx == LAST_IDX) begin
                        if (mode == MODE_ONESHOT) begin
                            done_q <= 1'b1;
                        end else begin
                            anim_idx <= '0;
                            hold_cnt <= HOLD_ONE;
                        end
                    end else begin
                        anim_idx <= anim_idx + IDX_W'(1);
                        hold_cnt <= HOLD_ONE;
                    end
                end else begin
                    hold_cnt <= hold_cnt + HOLD_ONE;
                end
            end
            if (mode != MODE_ONESHOT) begin
                done_q <= 1'b0;
            end
        end
    end

    // The done flag is only meaningful while one-shot mode is selected.
    always_comb begin
        anim_done = done_q & (mode == MODE_ONESHOT);
    end

endmodule

// File: rtl/sprite_anim_drawer.sv
// Animated sprite drawer: turns the scan position into a sprite ROM address
// and, three cycles later, a transparency-gated sprite_on and palette index.
module sprite_anim_drawer
    import sprite_pkg::*;
#(
    parameter int ADDR_W       = 18,
    parameter int COLOR_W      = 4,
    parameter int NUM_FRAMES   = 2,
    parameter int SIZE_X       = RUNNER_SIZE_X,
    parameter int SIZE_Y       = RUNNER_SIZE_Y,
    parameter int BASE0        = RUNNER_BASE,
    parameter int FRAME_STRIDE = SIZE_X * SIZE_Y,
    parameter int FRAME_HOLD   = 10,
    parameter int TRANSPARENT  = DEFAULT_TRANSPARENT
) (
    input  logic                          pixel_Clk,
    input  logic                          Reset,
    input  logic                          frame_tick,
    input  logic [9:0]                    DrawX,
    input  logic [9:0]                    DrawY,
    input  logic [9:0]                    PosX,
    input  logic [9:0]                    PosY,
    input  logic [1:0]                    mode,
    input  logic                          flip_x,
    input  logic                          restart,
    input  logic [COLOR_W-1:0]            rom_data,
    output logic [ADDR_W-1:0]             address,
    output logic                          sprite_on,
    output logic [COLOR_W-1:0]            pixel_idx,
    output logic [$clog2(NUM_FRAMES):0]   anim_idx,
    output logic                          anim_done
);

    localparam logic [ADDR_W-1:0]  BASE_A   = ADDR_W'(BASE0);
    localparam logic [ADDR_W-1:0]  STRIDE_A = ADDR_W'(FRAME_STRIDE);
    localparam logic [ADDR_W-1:0]  SIZEX_A  = ADDR_W'(SIZE_X);
    localparam logic [COLOR_W-1:0] KEY      = COLOR_W'(TRANSPARENT);

    anim_mode_t mode_e;

    logic [10:0]       draw_x11, draw_y11, pos_x11, pos_y11;
    logic [10:0]       dx, dy, col;
    logic              in_box;
    logic [ADDR_W-1:0] frame_base, addr_next;
    logic              in_box_d1, hide_d1, in_box_d2, hide_d2;

    anim_sequencer #(
        .NUM_FRAMES (NUM_FRAMES),
        .FRAME_HOLD (FRAME_HOLD)
    ) u_seq (
        .pixel_Clk  (pixel_Clk),
        .Reset      (Reset),
        .frame_tick (frame_tick),
        .restart    (restart),
        .mode       (mode_e),
        .anim_idx   (anim_idx),
        .anim_done  (anim_done)
    );

    // Stage 1 combinational: box test and address at 11 bits so edges never wrap.
    always_comb begin
        mode_e     = anim_mode_t'(mode);
        draw_x11   = {1'b0, DrawX};
        draw_y11   = {1'b0, DrawY};
        pos_x11    = {1'b0, PosX};
        pos_y11    = {1'b0, PosY};
        dx         = draw_x11 - pos_x11;
        dy         = draw_y11 - pos_y11;
        in_box     = (draw_x11 >= pos_x11) && (draw_x11 < pos_x11 + 11'(SIZE_X)) &&
                     (draw_y11 >= pos_y11) && (draw_y11 < pos_y11 + 11'(SIZE_Y));
        col        = flip_x ? (11'(SIZE_X - 1) - dx) : dx;
        frame_base = BASE_A + ADDR_W'(anim_idx) * STRIDE_A;
        addr_next  = frame_base;
        if (in_box) begin
            addr_next = frame_base + ADDR_W'(dy) * SIZEX_A + ADDR_W'(col);
        end
    end

    // Address register plus in_box/hide carried alongside the ROM read.
    always_ff @(posedge pixel_Clk) begin
        if (Reset) begin
            address   <= BASE_A;
            in_box_d1 <= 1'b0;
            hide_d1   <= 1'b0;
            in_box_d2 <= 1'b0;
            hide_d2   <= 1'b0;
        end else begin
            address   <= addr_next;
            in_box_d1 <= in_box;
            hide_d1   <= (mode_e == MODE_HIDE);
            in_box_d2 <= in_box_d1;
            hide_d2   <= hide_d1;
        end
    end

    // Output stage: ROM data is keyed against the transparent index.
    always_ff @(posedge pixel_Clk) begin
        if (Reset) begin
            sprite_on <= 1'b0;
            pixel_idx <= '0;
        end else begin
            sprite_on <= in_box_d2 & ~hide_d2 & (rom_data != KEY);
            pixel_idx <= (in_box_d2 & ~hide_d2 & (rom_data != KEY)) ? rom_data : '0;
        end
    end

endmodule

// File: tb/tb_sprite_anim_drawer.sv
// Self-checking bench for sprite_anim_drawer: table vectors, hand-built
// latency/reset/sequencer sequences and a randomized run against a model.
module tb_sprite_anim_drawer;
    import sprite_pkg::*;

    localparam int ADDR_W = 18;
    localparam int SX     = 88;
    localparam int SY     = 94;
    localparam int B0     = 207867;
    localparam int STRIDE = SX * SY;

    logic       pixel_Clk = 1'b0;
    logic       Reset, frame_tick, flip_x, restart;
    logic [9:0] DrawX, DrawY, PosX, PosY;
    logic [1:0] mode;
    logic [3:0] rom_data;

    logic [17:0] address, address1;
    logic        sprite_on, sprite_on1, anim_done, anim_done1;
    logic [3:0]  pixel_idx, pixel_idx1;
    logic [2:0]  anim_idx;
    logic [1:0]  anim_idx1;

    always #5 pixel_Clk = ~pixel_Clk;

    sprite_anim_drawer #(.NUM_FRAMES(3), .FRAME_HOLD(2)) dut (
        .pixel_Clk(pixel_Clk), .Reset(Reset), .frame_tick(frame_tick),
        .DrawX(DrawX), .DrawY(DrawY), .PosX(PosX), .PosY(PosY),
        .mode(mode), .flip_x(flip_x), .restart(restart), .rom_data(rom_data),
        .address(address), .sprite_on(sprite_on), .pixel_idx(pixel_idx),
        .anim_idx(anim_idx), .anim_done(anim_done)
    );

    sprite_anim_drawer #(.NUM_FRAMES(2), .FRAME_HOLD(1)) dut1 (
        .pixel_Clk(pixel_Clk), .Reset(Reset), .frame_tick(frame_tick),
        .DrawX(DrawX), .DrawY(DrawY), .PosX(PosX), .PosY(PosY),
        .mode(mode), .flip_x(flip_x), .restart(restart), .rom_data(rom_data),
        .address(address1), .sprite_on(sprite_on1), .pixel_idx(pixel_idx1),
        .anim_idx(anim_idx1), .anim_done(anim_done1)
    );

    int errors = 0;
    int checks = 0;

    // Reference model: animation position counted in ticks, pixel pipeline as flags.
    int     m_pos[2];
    bit     m_flag[2];
    int     m_nf[2] = '{3, 2};
    int     m_fh[2] = '{2, 1};
    bit     p1_in, p1_hide, p2_in, p2_hide;
    longint exp_addr;
    bit     exp_on;
    int     exp_pix;

    typedef struct {
        int       px, py, dx, dy;
        bit       flip;
        logic [1:0] md;
        int       rom;
        int       addr;
        bit       on;
        int       pix;
    } vec_t;

    vec_t tbl[11];
    int   loop_exp[12] = '{0, 1, 1, 2, 2, 0, 0, 1, 1, 2, 2, 0};

    task automatic chk(input string name, input longint act, input longint req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d at t=%0t", name, act, req, $time);
        end
    endtask

    task automatic step();
        int  x, y, px, py, dxv, dyv, col, idx0;
        bit  inb;
        longint a;
        @(posedge pixel_Clk);
        idx0 = m_pos[0] / m_fh[0];
        x = DrawX; y = DrawY; px = PosX; py = PosY;
        if (Reset) begin
            exp_addr = B0; exp_on = 0; exp_pix = 0;
            p1_in = 0; p1_hide = 0; p2_in = 0; p2_hide = 0;
        end else begin
            inb = (x >= px) && (x < px + SX) && (y >= py) && (y < py + SY);
            dxv = x - px; dyv = y - py;
            col = flip_x ? (SX - 1 - dxv) : dxv;
            a = B0 + idx0 * STRIDE;
            if (inb) a = a + dyv * SX + col;
            exp_addr = a % (64'd1 << ADDR_W);
            exp_on  = p2_in && !p2_hide && (rom_data != 4'd0);
            exp_pix = exp_on ? int'(rom_data) : 0;
            p2_in = p1_in; p2_hide = p1_hide;
            p1_in = inb;   p1_hide = (mode == 2'b11);
        end
        for (int k = 0; k < 2; k++) begin
            if (Reset || restart) begin
                m_pos[k] = 0; m_flag[k] = 0;
            end else begin
                if (frame_tick && mode == 2'b00)
                    m_pos[k] = (m_pos[k] + 1) % (m_nf[k] * m_fh[k]);
                else if (frame_tick && mode == 2'b10) begin
                    if (m_pos[k] == m_nf[k] * m_fh[k] - 1) m_flag[k] = 1;
                    else m_pos[k] = m_pos[k] + 1;
                end
                if (mode != 2'b10) m_flag[k] = 0;
            end
        end
        #1;
        chk("address",   address,   exp_addr);
        chk("sprite_on", sprite_on, exp_on);
        chk("pixel_idx", pixel_idx, exp_pix);
        chk("anim_idx",  anim_idx,  m_pos[0] / m_fh[0]);
        chk("anim_done", anim_done, m_flag[0] && mode == 2'b10);
        chk("anim_idx1", anim_idx1, m_pos[1] / m_fh[1]);
        chk("anim_done1", anim_done1, m_flag[1] && mode == 2'b10);
    endtask

    task automatic tick();
        frame_tick = 1; step(); frame_tick = 0; step();
    endtask

    initial begin
        // frame base for anim_idx=1 is 207867+8272 = 216139
        tbl[0]  = '{100, 50, 102, 53, 1'b0, 2'b01, 5, 216405, 1'b1, 5};
        tbl[1]  = '{100, 50, 102, 53, 1'b1, 2'b01, 5, 216488, 1'b1, 5};
        tbl[2]  = '{100, 50, 102, 53, 1'b0, 2'b01, 0, 216405, 1'b0, 0};
        tbl[3]  = '{100, 50, 102, 53, 1'b0, 2'b11, 5, 216405, 1'b0, 0};
        tbl[4]  = '{100, 50, 187, 50, 1'b0, 2'b01, 7, 216226, 1'b1, 7};
        tbl[5]  = '{100, 50, 188, 50, 1'b0, 2'b01, 7, 216139, 1'b0, 0};
        tbl[6]  = '{1000, 50, 5, 60, 1'b0, 2'b01, 7, 216139, 1'b0, 0};
        tbl[7]  = '{100, 50, 99, 60, 1'b0, 2'b01, 7, 216139, 1'b0, 0};
        tbl[8]  = '{100, 50, 100, 143, 1'b1, 2'b01, 3, 224410, 1'b1, 3};
        tbl[9]  = '{100, 50, 100, 144, 1'b1, 2'b01, 3, 216139, 1'b0, 0};
        tbl[10] = '{1000, 50, 1023, 50, 1'b0, 2'b01, 9, 216162, 1'b1, 9};

        Reset = 1; frame_tick = 0; restart = 0; flip_x = 0; mode = 2'b00;
        DrawX = 0; DrawY = 0; PosX = 100; PosY = 50; rom_data = 0;
        m_pos = '{0, 0}; m_flag = '{0, 0};
        step(); step();
        chk("rst_address", address, B0);
        chk("rst_sprite_on", sprite_on, 0);
        chk("rst_anim_idx", anim_idx, 0);
        Reset = 0;

        // Reach anim_idx=1 and freeze it for the table vectors.
        tick(); tick();
        mode = 2'b01;
        for (int i = 0; i < 11; i++) begin
            PosX = 10'(tbl[i].px); PosY = 10'(tbl[i].py);
            DrawX = 10'(tbl[i].dx); DrawY = 10'(tbl[i].dy);
            flip_x = tbl[i].flip; mode = tbl[i].md; rom_data = 4'(tbl[i].rom);
            repeat (4) step();
            chk($sformatf("tbl%0d_addr", i), address, tbl[i].addr);
            chk($sformatf("tbl%0d_on", i), sprite_on, tbl[i].on);
            chk($sformatf("tbl%0d_pix", i), pixel_idx, tbl[i].pix);
            chk($sformatf("tbl%0d_idx", i), anim_idx, 1);
        end

        // LOOP sequence, three frames held two ticks each.
        mode = 2'b00; flip_x = 0;
        restart = 1; step(); restart = 0;
        for (int i = 0; i < 12; i++) begin
            frame_tick = 1; step();
            chk($sformatf("loop_idx%0d", i), anim_idx, loop_exp[i]);
            frame_tick = 0; step();
        end

        // ONESHOT on the two-frame, one-tick instance.
        mode = 2'b10;
        restart = 1; step(); restart = 0;
        frame_tick = 1; step(); frame_tick = 0;
        chk("os_idx_t1", anim_idx1, 1); chk("os_done_t1", anim_done1, 0);
        step();
        frame_tick = 1; step(); frame_tick = 0;
        chk("os_idx_t2", anim_idx1, 1); chk("os_done_t2", anim_done1, 1);
        frame_tick = 1; step(); frame_tick = 0;
        chk("os_idx_t3", anim_idx1, 1); chk("os_done_t3", anim_done1, 1);
        frame_tick = 1; restart = 1; step(); frame_tick = 0; restart = 0;
        chk("os_rst_idx", anim_idx1, 0); chk("os_rst_done", anim_done1, 0);
        repeat (8) tick();
        mode = 2'b00; step();
        chk("os_leave_done", anim_done, 0);

        // Exact three-cycle latency from DrawX sample to sprite_on.
        mode = 2'b01; PosX = 100; PosY = 50; DrawY = 53; DrawX = 0; rom_data = 0;
        repeat (3) step();
        DrawX = 102; step();
        chk("lat_n1_on", sprite_on, 0);
        DrawX = 0; step();
        chk("lat_n2_on", sprite_on, 0);
        rom_data = 5; step();
        chk("lat_n3_on", sprite_on, 1); chk("lat_n3_pix", pixel_idx, 5);
        step();
        chk("lat_n4_on", sprite_on, 0);

        // Reset in the middle of a run of opaque pixels.
        DrawX = 102; rom_data = 5; repeat (4) step();
        chk("pre_rst_on", sprite_on, 1);
        Reset = 1; step(); Reset = 0;
        chk("mid_rst_addr", address, B0);
        chk("mid_rst_idx", anim_idx, 0);
        chk("mid_rst_on", sprite_on, 0);
        for (int i = 0; i < 3; i++) begin
            step();
            chk($sformatf("flush%0d_on", i), sprite_on, (i == 2) ? 1 : 0);
        end

        // Randomized run, every cycle compared against the model.
        for (int i = 0; i < 600; i++) begin
            Reset      = ($urandom_range(0, 63) == 0);
            restart    = ($urandom_range(0, 15) == 0);
            frame_tick = ($urandom_range(0, 2) == 0);
            if ($urandom_range(0, 7) == 0) mode = 2'($urandom_range(0, 3));
            flip_x   = 1'($urandom_range(0, 1));
            PosX     = 10'($urandom_range(0, 1023));
            PosY     = 10'($urandom_range(0, 1023));
            DrawX    = 10'((int'(PosX) + $urandom_range(0, 100) + 1014) % 1024);
            DrawY    = 10'((int'(PosY) + $urandom_range(0, 106) + 1018) % 1024);
            rom_data = ($urandom_range(0, 3) == 0) ? 4'd0 : 4'($urandom_range(1, 15));
            step();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
